btn_debounce_tick_amisha: RTL
=============================

// Module: btn_debounce_tick_amisha
// PURPOSE
//  Conditions the raw push-buttons that load the four 7-seg digit registers.
//  Per button: 2-FF synchroniser, then a debounce FSM with a down-counter.
//  Outputs a clean debounced level and a one-cycle press tick per button.
//  The ticks drive the digit-register load enables upstream of the display mux.
// PARAMETERS
//  N_BTN    4   number of independent button channels
//  DB_BITS  19  debounce counter width; stable time = 2^DB_BITS clks (~10 ms @ 50 MHz)
// PORTS
//  clk_amisha       in   1      system clock, all logic on rising edge
//  reset_amisha     in   1      asynchronous, active-high reset
//  btn_amisha       in   N_BTN  raw asynchronous button inputs, 1 = pressed
//  db_level_amisha  out  N_BTN  debounced button level, registered
//  db_tick_amisha   out  N_BTN  1-clk pulse on each debounced press (0->1 only)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: sync FFs=0, every FSM=ZERO, counters=0, db_level=0, db_tick=0, effective immediately.
//  Channels are fully independent; one sync pair, one FSM, one counter each.
//  Sync: s = btn delayed by 2 FFs; the FSM sees only s.
//  M = 2^DB_BITS-1. Counter width is DB_BITS; it never wraps. It only loads M or decrements toward 0.
//  FSM states and transitions:
//   ZERO : level 0. If s=1 -> WAIT1 and cnt<=M.
//   WAIT1: level 0. If s=0 -> ZERO. Else if cnt==0 -> ONE and tick<=1. Else cnt<=cnt-1.
//   ONE  : level 1. If s=0 -> WAIT0 and cnt<=M.
//   WAIT0: level 1. If s=1 -> ONE, with no tick. Else if cnt==0 -> ZERO. Else cnt<=cnt-1.
//  s=0 in WAIT1 (and s=1 in WAIT0) wins over cnt==0 on the same edge.
//  db_level = registered (state==ONE or WAIT0). db_tick is registered, high exactly 1 clk.
//  The tick coincides with the first cycle of ONE.
//  Latency: edge 1 is the first edge that samples btn=1.
//   With btn held, db_level and db_tick rise after edge 2^DB_BITS+3.
//   db_tick clears on the next edge. Release: db_level falls after edge 2^DB_BITS+3, no tick.
//  Bounce: any s reversal during WAIT1/WAIT0 restarts the qualification.
//   Full qualification is needed again from the next stable level.
//  No falling-edge tick. No repeat ticks while held.
//  Reset mid-wait aborts the wait: no tick, no stale count.
//  A button still held after reset release produces a fresh tick after 2^DB_BITS+3 edges.
// TESTING  (DB_BITS=4, so M=15 and latency=19 edges)
//  Reset asserted async mid-cycle -> db_level=0 and db_tick=0 immediately; stays so while held.
//  btn[0] 0->1 held -> db_tick[0]=1 only after edge 19, db_level[0]=1 from edge 19, tick 0 after edge 20.
//  btn[1] bounce 5 hi/3 lo x3, then held -> exactly one tick, 19 edges after the final rising sample.
//  btn[2] high 10 clks then low -> no tick, db_level[2] stays 0.
//  btn[0] held, released 8 clks, re-pressed -> db_level[0] stays 1, no tick.
//  Full release then gives the level fall 19 edges after release.
//  All 4 pressed on the same edge -> all 4 ticks in the same cycle.
//  Reset at edge 10 of a WAIT1 -> no tick; after reset drop, a held button ticks 19 edges later.

Source files
------------

// File: rtl/btn_debounce_tick_amisha.sv
// rtl/btn_debounce_tick_amisha.sv - per-button synchroniser, debounce FSM and press tick
//
// Purpose:
//   Conditions the raw push-buttons that load the four 7-seg digit registers.
//   Each channel has a 2-FF synchroniser feeding a four-state debounce FSM
//   with a down-counter.  A level change is accepted only after the
//   synchronised input has stayed at the new value for 2^DB_BITS clocks.
//   Each channel outputs a registered debounced level and a one-clock tick
//   on every accepted press (0->1 only).
//
// Ports:
//   clk_amisha       in   1      system clock, rising edge
//   reset_amisha     in   1      asynchronous, active-high reset
//   btn_amisha       in   N_BTN  raw asynchronous buttons, 1 = pressed
//   db_level_amisha  out  N_BTN  debounced level, registered
//   db_tick_amisha   out  N_BTN  one-clock pulse on each debounced press

module btn_debounce_tick_amisha #(
    parameter int N_BTN   = 4,
    parameter int DB_BITS = 19
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic [N_BTN-1:0] btn_amisha,
    output logic [N_BTN-1:0] db_level_amisha,
    output logic [N_BTN-1:0] db_tick_amisha
);

    localparam logic [1:0] ST_ZERO  = 2'd0;
    localparam logic [1:0] ST_WAIT1 = 2'd1;
    localparam logic [1:0] ST_ONE   = 2'd2;
    localparam logic [1:0] ST_WAIT0 = 2'd3;

    localparam logic [DB_BITS-1:0] CNT_MAX = {DB_BITS{1'b1}};

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        logic               sync1_q, sync1_d;
        logic               sync2_q, sync2_d;
        logic [1:0]         state_q, state_d;
        logic [DB_BITS-1:0] cnt_q, cnt_d;
        logic               level_q, level_d;
        logic               tick_q, tick_d;
        logic               s;

        assign s = sync2_q;

        always_comb begin
            sync1_d = btn_amisha[g];
            sync2_d = sync1_q;
            state_d = state_q;
            cnt_d   = cnt_q;
            tick_d  = 1'b0;

            case (state_q)
                ST_ZERO: begin
                    if (s) begin
                        state_d = ST_WAIT1;
                        cnt_d   = CNT_MAX;
                    end
                end
                ST_WAIT1: begin
                    // A reversal beats an expiring count on the same edge.
                    if (!s) begin
                        state_d = ST_ZERO;
                    end else if (cnt_q == '0) begin
                        state_d = ST_ONE;
                        tick_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_ONE: begin
                    if (!s) begin
                        state_d = ST_WAIT0;
                        cnt_d   = CNT_MAX;
                    end
                end
                default: begin
                    // Return to ONE on a short release is silent: no tick.
                    if (s) begin
                        state_d = ST_ONE;
                    end else if (cnt_q == '0) begin
                        state_d = ST_ZERO;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase

            // Registered from the next state so level and tick rise together.
            level_d = (state_d == ST_ONE) || (state_d == ST_WAIT0);
        end

        always_ff @(posedge clk_amisha or posedge reset_amisha) begin
            if (reset_amisha) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= ST_ZERO;
                cnt_q   <= '0;
                level_q <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                tick_q  <= tick_d;
            end
        end

        assign db_level_amisha[g] = level_q;
        assign db_tick_amisha[g]  = tick_q;
    end

endmodule
